ads1278_frame_reader: RTL and testbench

- Upstream master interface for the ADS1278 8-channel 24-bit ADC, in the sys_clk domain.
- Generates the converter master clock (o_ads1278_clk) and serial clock (o_ads1278_sclk).
- Detects DRDY, shifts one full TDM frame (NUM_CH x DATA_W bits) in from DOUT, and presents each channel word with a one-cycle valid strobe to the receive/analysis logic.

---
 rtl/ads1278_frame_reader.sv | 171 +++++++++++++++++
 tb/tb_ads1278_frame_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1278_frame_reader.sv
// rtl/ads1278_frame_reader.sv - ADS1278 master clock, DRDY detect and TDM frame deserializer
module ads1278_frame_reader #(
  parameter int CLK_DIV  = 4,
  parameter int SCLK_DIV = 4,
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              i_enable,
  input  logic              i_ads1278_drdy_n,
  input  logic              i_ads1278_dout,
  output logic              o_ads1278_clk,
  output logic              o_ads1278_sclk,
  output logic [DATA_W-1:0] o_ch_data,
  output logic [2:0]        o_ch_idx,
  output logic              o_ch_valid,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int CLK_CW  = $clog2(CLK_DIV + 1);
  localparam int SCLK_CW = $clog2(SCLK_DIV + 1);
  localparam int BIT_CW  = $clog2(DATA_W + 1);

  localparam logic [CLK_CW-1:0]  CLK_LAST  = CLK_CW'(CLK_DIV - 1);
  localparam logic [SCLK_CW-1:0] SCLK_LAST = SCLK_CW'(SCLK_DIV - 1);
  localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(DATA_W - 1);
  localparam logic [2:0]         CH_LAST   = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DRDY,
    ST_SHIFT
  } state_t;

  state_t state;
  state_t state_next;

  logic [CLK_CW-1:0]  clk_cnt;
  logic [SCLK_CW-1:0] sclk_cnt;
  logic [BIT_CW-1:0]  bit_cnt;
  logic [2:0]         ch_cnt;
  logic [DATA_W-2:0]  shift_reg;

  logic drdy_meta;
  logic drdy_sync;
  logic drdy_prev;
  logic dout_meta;
  logic dout_sync;

  logic drdy_event;
  logic sclk_tick;
  logic sample;
  logic word_done;
  logic frame_last;

  // The last sample of a word completes it; the incoming bit is the LSB.
  assign drdy_event = drdy_prev & ~drdy_sync;
  assign sclk_tick  = (sclk_cnt == SCLK_LAST);
  assign sample     = (state == ST_SHIFT) && o_ads1278_sclk && sclk_tick;
  assign word_done  = sample && (bit_cnt == BIT_LAST);
  assign frame_last = word_done && (ch_cnt == CH_LAST);

  // Free-running converter master clock, independent of acquisition state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      clk_cnt       <= '0;
      o_ads1278_clk <= 1'b0;
    end else if (clk_cnt == CLK_LAST) begin
      clk_cnt       <= '0;
      o_ads1278_clk <= ~o_ads1278_clk;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  // Two-stage synchronizers for the asynchronous ADC outputs plus DRDY edge history.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      drdy_meta <= 1'b1;
      drdy_sync <= 1'b1;
      drdy_prev <= 1'b1;
      dout_meta <= 1'b0;
      dout_sync <= 1'b0;
    end else begin
      drdy_meta <= i_ads1278_drdy_n;
      drdy_sync <= drdy_meta;
      drdy_prev <= drdy_sync;
      dout_meta <= i_ads1278_dout;
      dout_sync <= dout_meta;
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a frame in progress always runs to completion.
  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_enable) state_next = ST_WAIT_DRDY;
      end
      ST_WAIT_DRDY: begin
        if (!i_enable)       state_next = ST_IDLE;
        else if (drdy_event) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        o_busy = 1'b1;
        if (frame_last) state_next = i_enable ? ST_WAIT_DRDY : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Serial clock generation and bit/channel counting while shifting.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || (state != ST_SHIFT)) begin
      sclk_cnt       <= '0;
      o_ads1278_sclk <= 1'b0;
      bit_cnt        <= '0;
      ch_cnt         <= '0;
      shift_reg      <= '0;
    end else begin
      if (sclk_tick) begin
        sclk_cnt       <= '0;
        o_ads1278_sclk <= ~o_ads1278_sclk;
      end else begin
        sclk_cnt <= sclk_cnt + 1'b1;
      end
      if (sample) begin
        shift_reg <= {shift_reg[DATA_W-3:0], dout_sync};
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          ch_cnt  <= (ch_cnt == CH_LAST) ? 3'd0 : ch_cnt + 3'd1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Registered word presentation and status strobes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      o_ch_data    <= '0;
      o_ch_idx     <= '0;
      o_ch_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_ch_valid   <= word_done;
      o_frame_done <= frame_last;
      o_overrun    <= drdy_event && (state == ST_SHIFT);
      if (word_done) begin
        o_ch_data <= {shift_reg, dout_sync};
        o_ch_idx  <= ch_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ads1278_frame_reader.sv
// tb/tb_ads1278_frame_reader.sv - directed self-checking bench for ads1278_frame_reader
module tb_ads1278_frame_reader;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic        drdy_n = 1'b1;
  logic        ads_dout;
  logic        o_ads1278_clk;
  logic        o_ads1278_sclk;
  logic [23:0] o_ch_data;
  logic [2:0]  o_ch_idx;
  logic        o_ch_valid;
  logic        o_frame_done;
  logic        o_busy;
  logic        o_overrun;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  ads1278_frame_reader #(
    .CLK_DIV(4), .SCLK_DIV(4), .NUM_CH(8), .DATA_W(24)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .i_enable(i_enable),
    .i_ads1278_drdy_n(drdy_n),
    .i_ads1278_dout(ads_dout),
    .o_ads1278_clk(o_ads1278_clk),
    .o_ads1278_sclk(o_ads1278_sclk),
    .o_ch_data(o_ch_data),
    .o_ch_idx(o_ch_idx),
    .o_ch_valid(o_ch_valid),
    .o_frame_done(o_frame_done),
    .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  // ADC model: MSB of ch0 appears on DRDY fall, next bit after each sclk falling edge.
  logic [191:0] adc_frame = '0;
  int           adc_pos = 192;
  logic         sclk_last = 1'b0;

  assign ads_dout = (adc_pos < 192) ? adc_frame[191 - adc_pos] : 1'b0;

  always @(negedge drdy_n or posedge o_ads1278_sclk or negedge o_ads1278_sclk) begin
    if (o_ads1278_sclk !== sclk_last) begin
      if (!o_ads1278_sclk && adc_pos < 192) adc_pos <= adc_pos + 1;
      sclk_last <= o_ads1278_sclk;
    end else if (!drdy_n && !o_busy) begin
      adc_pos <= 0;
    end
  end

  // Output monitor, sampled on the falling system clock edge.
  int          n_valid = 0, n_done = 0, n_fd_bad = 0, n_ovr = 0, n_rise = 0, n_busy = 0;
  logic        sclk_prev_m = 1'b0;
  logic [23:0] rx_data[$];
  logic [2:0]  rx_idx[$];

  always @(negedge sys_clk) begin
    if (o_ch_valid) begin
      rx_data.push_back(o_ch_data);
      rx_idx.push_back(o_ch_idx);
      n_valid <= n_valid + 1;
    end
    if (o_frame_done) begin
      n_done <= n_done + 1;
      if (!(o_ch_valid && o_ch_idx == 3'd7)) n_fd_bad <= n_fd_bad + 1;
    end
    if (o_overrun) n_ovr <= n_ovr + 1;
    if (o_ads1278_sclk && !sclk_prev_m) n_rise <= n_rise + 1;
    sclk_prev_m <= o_ads1278_sclk;
    if (o_busy) n_busy <= n_busy + 1;
  end

  function automatic logic [23:0] base_word(int ch);
    case (ch)
      0: return 24'h800001;
      1: return 24'h7FFFFF;
      2: return 24'h000000;
      3: return 24'hFFFFFF;
      4: return 24'hA5A5A5;
      5: return 24'h5A5A5A;
      6: return 24'h123456;
      default: return 24'hFEDCBA;
    endcase
  endfunction

  function automatic logic [191:0] make_frame(logic [23:0] x);
    logic [191:0] f = '0;
    for (int ch = 0; ch < 8; ch++) f = {f[167:0], base_word(ch) ^ x};
    return f;
  endfunction

  task automatic cycles(int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_drdy();
    drdy_n = 1'b0;
    cycles(10);
    drdy_n = 1'b1;
  endtask

  task automatic wait_valids(int target, int budget, output bit ok);
    int i = 0;
    ok = 1'b0;
    while (i < budget && !ok) begin
      if (n_valid >= target) ok = 1'b1;
      else cycles(1);
      i++;
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    i_enable = 1'b0;
    cycles(5);
    checks += 8;
    if (o_ch_data !== 24'd0)    begin errors++; $display("FAIL reset_data got %h want 000000", o_ch_data); end
    if (o_ch_idx !== 3'd0)      begin errors++; $display("FAIL reset_idx got %0d want 0", o_ch_idx); end
    if (o_ch_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got %b want 0", o_ch_valid); end
    if (o_frame_done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", o_frame_done); end
    if (o_busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    if (o_overrun !== 1'b0)     begin errors++; $display("FAIL reset_overrun got %b want 0", o_overrun); end
    if (o_ads1278_clk !== 1'b0) begin errors++; $display("FAIL reset_clk got %b want 0", o_ads1278_clk); end
    if (o_ads1278_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", o_ads1278_sclk); end
    sys_rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      logic exp_clk;
      cycles(1);
      exp_clk = ((k / 4) % 2) == 1;
      checks++;
      if (o_ads1278_clk !== exp_clk) begin
        errors++;
        $display("FAIL mclk_cycle%0d got %b want %b", k, o_ads1278_clk, exp_clk);
      end
    end
  endtask

  task automatic test_single_frame();
    int base, d0, f0, r0, b0, o0;
    bit ok;
    adc_frame = make_frame(24'h0);
    i_enable = 1'b1;
    cycles(2);
    base = n_valid; d0 = n_done; f0 = n_fd_bad; r0 = n_rise; b0 = n_busy; o0 = n_ovr;
    pulse_drdy();
    wait_valids(base + 8, 3000, ok);
    cycles(5);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got %0d valids want 8", n_valid - base); end
    for (int ch = 0; ch < 8; ch++) begin
      if (rx_data.size() > base + ch) begin
        checks += 2;
        if (rx_data[base + ch] !== base_word(ch)) begin
          errors++; $display("FAIL single_data ch%0d got %h want %h", ch, rx_data[base + ch], base_word(ch));
        end
        if (rx_idx[base + ch] !== 3'(ch)) begin
          errors++; $display("FAIL single_idx pos%0d got %0d want %0d", ch, rx_idx[base + ch], ch);
        end
      end
    end
    checks += 5;
    if (n_done - d0 != 1)    begin errors++; $display("FAIL single_done got %0d want 1", n_done - d0); end
    if (n_fd_bad - f0 != 0)  begin errors++; $display("FAIL single_done_align got %0d misaligned want 0", n_fd_bad - f0); end
    if (n_rise - r0 != 192)  begin errors++; $display("FAIL single_sclk_rises got %0d want 192", n_rise - r0); end
    if (n_busy - b0 != 1536) begin errors++; $display("FAIL single_busy_cycles got %0d want 1536", n_busy - b0); end
    if (n_ovr - o0 != 0)     begin errors++; $display("FAIL single_overrun got %0d want 0", n_ovr - o0); end
  endtask

  task automatic test_overrun();
    int base, d0, b0, o0;
    bit ok;
    adc_frame = make_frame(24'h0F0F0F);
    i_enable = 1'b1;
    base = n_valid; d0 = n_done; b0 = n_busy; o0 = n_ovr;
    pulse_drdy();
    cycles(490);
    pulse_drdy();
    wait_valids(base + 8, 3000, ok);
    cycles(5);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL overrun_timeout got %0d valids want 8", n_valid - base); end
    if (n_ovr - o0 != 1)  begin errors++; $display("FAIL overrun_pulses got %0d want 1", n_ovr - o0); end
    if (n_done - d0 != 1) begin errors++; $display("FAIL overrun_done got %0d want 1", n_done - d0); end
    for (int ch = 0; ch < 8; ch++) begin
      if (rx_data.size() > base + ch) begin
        checks++;
        if (rx_data[base + ch] !== (base_word(ch) ^ 24'h0F0F0F)) begin
          errors++; $display("FAIL overrun_data ch%0d got %h want %h", ch, rx_data[base + ch], base_word(ch) ^ 24'h0F0F0F);
        end
      end
    end
    cycles(2000);
    checks += 2;
    if (n_valid - base != 8)  begin errors++; $display("FAIL overrun_extra_valids got %0d want 8", n_valid - base); end
    if (n_busy - b0 != 1536)  begin errors++; $display("FAIL overrun_extra_frame got %0d busy want 1536", n_busy - b0); end
  endtask

  task automatic test_enable_drop();
    int base, r_mid, b_mid;
    bit ok3, ok8;
    adc_frame = make_frame(24'h333333);
    i_enable = 1'b1;
    base = n_valid;
    pulse_drdy();
    wait_valids(base + 3, 3000, ok3);
    i_enable = 1'b0;
    wait_valids(base + 8, 3000, ok8);
    cycles(5);
    checks += 3;
    if (!(ok3 && ok8)) begin errors++; $display("FAIL endrop_timeout got %0d valids want 8", n_valid - base); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL endrop_busy got %b want 0", o_busy); end
    if (rx_data.size() > base + 7 && rx_data[base + 7] !== (base_word(7) ^ 24'h333333)) begin
      errors++; $display("FAIL endrop_last_word got %h want %h", rx_data[base + 7], base_word(7) ^ 24'h333333);
    end
    r_mid = n_rise; b_mid = n_busy;
    pulse_drdy();
    cycles(2000);
    checks += 3;
    if (n_rise != r_mid)     begin errors++; $display("FAIL endrop_idle_sclk got %0d rises want 0", n_rise - r_mid); end
    if (n_busy != b_mid)     begin errors++; $display("FAIL endrop_idle_busy got %0d cycles want 0", n_busy - b_mid); end
    if (n_valid - base != 8) begin errors++; $display("FAIL endrop_valids got %0d want 8", n_valid - base); end
  endtask

  task automatic test_reset_mid();
    int base, base2;
    bit ok;
    adc_frame = make_frame(24'h555555);
    i_enable = 1'b1;
    cycles(2);
    base = n_valid;
    pulse_drdy();
    wait_valids(base + 5, 3000, ok);
    cycles(20);
    sys_rst = 1'b1;
    cycles(1);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout got %0d valids want 5", n_valid - base); end
    if (o_ads1278_sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got %b want 0", o_ads1278_sclk); end
    if (o_ch_valid !== 1'b0)     begin errors++; $display("FAIL rstmid_valid got %b want 0", o_ch_valid); end
    if (o_busy !== 1'b0)         begin errors++; $display("FAIL rstmid_busy got %b want 0", o_busy); end
    cycles(2);
    sys_rst = 1'b0;
    cycles(2000);
    checks++;
    if (n_valid - base != 5) begin errors++; $display("FAIL rstmid_partial got %0d valids want 5", n_valid - base); end
    i_enable = 1'b0;
    cycles(2);
    i_enable = 1'b1;
    cycles(2);
    base2 = n_valid;
    pulse_drdy();
    wait_valids(base2 + 8, 3000, ok);
    cycles(5);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_refill got %0d valids want 8", n_valid - base2); end
    for (int ch = 0; ch < 8; ch++) begin
      if (rx_data.size() > base2 + ch) begin
        checks += 2;
        if (rx_idx[base2 + ch] !== 3'(ch)) begin
          errors++; $display("FAIL rstmid_idx pos%0d got %0d want %0d", ch, rx_idx[base2 + ch], ch);
        end
        if (rx_data[base2 + ch] !== (base_word(ch) ^ 24'h555555)) begin
          errors++; $display("FAIL rstmid_data ch%0d got %h want %h", ch, rx_data[base2 + ch], base_word(ch) ^ 24'h555555);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, d0, o0;
    logic [23:0] x;
    i_enable = 1'b1;
    cycles(2);
    base = n_valid; d0 = n_done; o0 = n_ovr;
    for (int f = 0; f < 4; f++) begin
      x = 24'(f) * 24'h111111;
      adc_frame = make_frame(x);
      pulse_drdy();
      cycles(1590);
    end
    cycles(50);
    checks += 3;
    if (n_valid - base != 32) begin errors++; $display("FAIL b2b_valids got %0d want 32", n_valid - base); end
    if (n_done - d0 != 4)     begin errors++; $display("FAIL b2b_done got %0d want 4", n_done - d0); end
    if (n_ovr - o0 != 0)      begin errors++; $display("FAIL b2b_overrun got %0d want 0", n_ovr - o0); end
    for (int f = 0; f < 4; f++) begin
      x = 24'(f) * 24'h111111;
      for (int ch = 0; ch < 8; ch++) begin
        if (rx_data.size() > base + 8 * f + ch) begin
          checks++;
          if (rx_data[base + 8 * f + ch] !== (base_word(ch) ^ x) || rx_idx[base + 8 * f + ch] !== 3'(ch)) begin
            errors++;
            $display("FAIL b2b_word f%0d ch%0d got %h/%0d want %h/%0d", f, ch,
                     rx_data[base + 8 * f + ch], rx_idx[base + 8 * f + ch], base_word(ch) ^ x, ch);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
